// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM between N_REQ requesters, with a tagged return pipeline.
// Define SPRITE_ARB_STATS_EN to add a per-frame grant counter on stat_grants.
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 24,
  parameter int ROM_LAT = 2
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_start,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      rom_rd,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_q,
  output logic                      busy
`ifdef SPRITE_ARB_STATS_EN
  , output logic [15:0]             stat_grants
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0]              rr;
  logic [IDX_W-1:0]              win;
  logic                          hit;
  logic [ADDR_W-1:0]             addr_q;
  logic [ROM_LAT:1]              vld_pipe;
  logic [ROM_LAT:1][IDX_W-1:0]   tag_pipe;
  logic [N_REQ-1:0]              rvalid_q;
  logic [DATA_W-1:0]             rdata_q;

  // Search from rr upward, wrapping at N_REQ (not at 2**IDX_W).
  always_comb begin
    int j;
    win = '0;
    hit = 1'b0;
    j   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!hit && req[j]) begin
        hit = 1'b1;
        win = IDX_W'(j);
      end
    end
  end

  always_comb begin
    grant    = '0;
    rom_rd   = 1'b0;
    rom_addr = '0;
    if (Reset) begin
      rom_rd   = hit;
      rom_addr = addr_q;
      if (hit) begin
        grant[win] = 1'b1;
        rom_addr   = req_addr[int'(win)*ADDR_W +: ADDR_W];
      end
    end
  end

  // Outputs forced low during reset so stale state never leaks before the first sampled edge.
  assign rvalid = Reset ? rvalid_q : '0;
  assign rdata  = Reset ? rdata_q  : '0;
  assign busy   = Reset & ((|vld_pipe) | (|rvalid_q));

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      rr       <= '0;
      addr_q   <= '0;
      vld_pipe <= '0;
      tag_pipe <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (frame_start)
        rr <= '0;
      else if (rom_rd)
        rr <= (int'(win) == N_REQ-1) ? '0 : win + 1'b1;
      if (rom_rd) addr_q <= rom_addr;
      vld_pipe[1] <= rom_rd;
      tag_pipe[1] <= win;
      for (int s = 2; s <= ROM_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        tag_pipe[s] <= tag_pipe[s-1];
      end
      rvalid_q <= '0;
      if (vld_pipe[ROM_LAT]) begin
        rvalid_q[tag_pipe[ROM_LAT]] <= 1'b1;
        rdata_q                     <= rom_q;
      end
    end
  end

`ifdef SPRITE_ARB_STATS_EN
  logic [15:0] grant_cnt;
  logic [15:0] cnt_next;

  assign cnt_next = (rom_rd && grant_cnt != 16'hFFFF) ? grant_cnt + 16'd1 : grant_cnt;

  // A grant coincident with frame_start is counted in the closing frame and seeds the new one.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      grant_cnt   <= '0;
      stat_grants <= '0;
    end else if (frame_start) begin
      stat_grants <= cnt_next;
      grant_cnt   <= rom_rd ? 16'd1 : 16'd0;
    end else begin
      grant_cnt <= cnt_next;
    end
  end
`endif

endmodule
